// File: rtl/alu_core.sv
// Registered 32-bit RV32I integer ALU: ten register/immediate operations,
// one-cycle latency, with valid and zero flags for branch/control logic.
module alu_core (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_en,
    input  logic [3:0]  I_alusel,
    input  logic [31:0] I_data1,
    input  logic [31:0] I_data2,
    output logic [31:0] O_data,
    output logic        O_valid,
    output logic        O_zero
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b1000,
        OP_SLL  = 4'b0001,
        OP_SLT  = 4'b0010,
        OP_SLTU = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SRA  = 4'b1101,
        OP_OR   = 4'b0110,
        OP_AND  = 4'b0111
    } alu_op_e;

    logic [31:0] result_d;
    logic [31:0] data_q;
    logic        valid_q;
    logic        zero_q;
    logic [4:0]  shamt_s;

    // Shift amount is the low five bits of operand B only.
    assign shamt_s = I_data2[4:0];

    // Combinational result selection; undefined codes produce zero.
    always_comb begin
        result_d = 32'd0;
        case (I_alusel)
            OP_ADD:  result_d = I_data1 + I_data2;
            OP_SUB:  result_d = I_data1 - I_data2;
            OP_SLL:  result_d = I_data1 << shamt_s;
            OP_SLT:  result_d = {31'd0, ($signed(I_data1) < $signed(I_data2))};
            OP_SLTU: result_d = {31'd0, (I_data1 < I_data2)};
            OP_XOR:  result_d = I_data1 ^ I_data2;
            OP_SRL:  result_d = I_data1 >> shamt_s;
            OP_SRA:  result_d = $unsigned($signed(I_data1) >>> shamt_s);
            OP_OR:   result_d = I_data1 | I_data2;
            OP_AND:  result_d = I_data1 & I_data2;
            default: result_d = 32'd0;
        endcase
    end

    // Output registers: load on strobe, otherwise hold data/zero and drop valid.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            data_q  <= 32'd0;
            valid_q <= 1'b0;
            zero_q  <= 1'b1;
        end else if (I_en) begin
            data_q  <= result_d;
            valid_q <= 1'b1;
            zero_q  <= (result_d == 32'd0);
        end else begin
            data_q  <= data_q;
            valid_q <= 1'b0;
            zero_q  <= zero_q;
        end
    end

    assign O_data  = data_q;
    assign O_valid = valid_q;
    assign O_zero  = zero_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed self-checking bench for alu_core with hand-computed expected values.
module tb_alu_core;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  alusel;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] o_data;
    logic        o_valid;
    logic        o_zero;

    int checks_cnt;
    int fail_cnt;

    alu_core dut (
        .I_clk    (clk),
        .I_rst    (rst),
        .I_en     (en),
        .I_alusel (alusel),
        .I_data1  (data1),
        .I_data2  (data2),
        .O_data   (o_data),
        .O_valid  (o_valid),
        .O_zero   (o_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Apply one operation between edges and check the registered result one edge later.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        en     = 1'b1;
        alusel = op;
        data1  = a;
        data2  = b;
        @(posedge clk);
        #1;
        check({tag, " data"},  o_data, exp);
        check({tag, " valid"}, {31'd0, o_valid}, 32'd1);
        check({tag, " zero"},  {31'd0, o_zero}, {31'd0, (exp == 32'd0)});
    endtask

    logic [3:0]  ops   [10] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                                4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};
    string       names [10] = '{"ADD", "SUB", "SLL", "SLT", "SLTU",
                                "XOR", "SRL", "SRA", "OR", "AND"};
    logic [31:0] exp_a [10] = '{32'd4, 32'd2, 32'd6, 32'd0, 32'd0,
                                32'd2, 32'd1, 32'd1, 32'd3, 32'd1};
    logic [31:0] exp_b [10] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'hFFFF_FFFA, 32'd1, 32'd0,
                                32'hFFFF_FFFC, 32'h7FFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
    logic [31:0] exp_c [10] = '{32'hFFFF_FFFE, 32'd4, 32'h2000_0000, 32'd0, 32'd1,
                                32'hFFFF_FFFC, 32'd0, 32'd0, 32'hFFFF_FFFD, 32'd1};
    logic [31:0] exp_d [10] = '{32'hFFFF_FFFE, 32'd0, 32'h8000_0000, 32'd0, 32'd0,
                                32'd0, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        rst    = 1'b1;
        en     = 1'b0;
        alusel = 4'd0;
        data1  = 32'd0;
        data2  = 32'd0;
        #12;
        check("reset data",  o_data, 32'd0);
        check("reset valid", {31'd0, o_valid}, 32'd0);
        check("reset zero",  {31'd0, o_zero}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Idle after release: outputs hold, valid stays low.
        repeat (2) @(posedge clk);
        #1;
        check("idle data",  o_data, 32'd0);
        check("idle valid", {31'd0, o_valid}, 32'd0);
        check("idle zero",  {31'd0, o_zero}, 32'd1);

        for (int i = 0; i < 10; i++) run_op({"A3B1 ", names[i]}, ops[i], 32'd3, 32'd1, exp_a[i]);
        for (int i = 0; i < 10; i++) run_op({"Am3B1 ", names[i]}, ops[i], 32'hFFFF_FFFD, 32'd1, exp_b[i]);
        for (int i = 0; i < 10; i++) run_op({"A1Bm3 ", names[i]}, ops[i], 32'd1, 32'hFFFF_FFFD, exp_c[i]);
        for (int i = 0; i < 10; i++) run_op({"Am1Bm1 ", names[i]}, ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, exp_d[i]);

        // Hold: strobe low keeps data/zero, valid drops.
        run_op("pre-hold ADD", 4'b0000, 32'd40, 32'd2, 32'd42);
        @(negedge clk);
        en    = 1'b0;
        data1 = 32'd7;
        data2 = 32'd9;
        @(posedge clk);
        #1;
        check("hold data",  o_data, 32'd42);
        check("hold valid", {31'd0, o_valid}, 32'd0);
        check("hold zero",  {31'd0, o_zero}, 32'd0);

        // Back-to-back operations.
        run_op("pipe ADD", 4'b0000, 32'd1, 32'd3, 32'd4);
        run_op("pipe SUB", 4'b1000, 32'd1, 32'd3, 32'hFFFF_FFFE);
        run_op("pipe SLT", 4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd0);

        // Undefined select codes produce zero.
        run_op("undef 1111", 4'b1111, 32'd5, 32'd6, 32'd0);
        run_op("undef 1001", 4'b1001, 32'd5, 32'd6, 32'd0);
        run_op("undef 1100", 4'b1100, 32'd5, 32'd6, 32'd0);

        // Asynchronous reset between edges clears a nonzero result immediately.
        run_op("pre-reset OR", 4'b0110, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF);
        #2;
        rst = 1'b1;
        #1;
        check("async rst data",  o_data, 32'd0);
        check("async rst valid", {31'd0, o_valid}, 32'd0);
        check("async rst zero",  {31'd0, o_zero}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        @(posedge clk);
        #1;
        check("post rst data",  o_data, 32'd0);
        check("post rst valid", {31'd0, o_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
